// File: rtl/chase_sched.sv
// chase_sched: 8-LED bouncing 3-LED meteor chaser with debounced mode/speed buttons and red/green routing
//   in : clk, reset (async, active-high), btn_mode, btn_speed (raw, asynchronous)
//   out: shiftR_out/shiftG_out (LED banks, bit 7 leftmost), ctl_bit (bank enable, always 1),
//        mode (colour mode), speed (step-rate level)
module chase_sched #(
   parameter int BASE_EXP = 20,
   parameter int DEB_EXP  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_speed,
   output logic [7:0] shiftR_out,
   output logic [7:0] shiftG_out,
   output logic       ctl_bit,
   output logic [1:0] mode,
   output logic [1:0] speed
);
   typedef enum logic {RIGHT, LEFT} dir_t;
   logic [1:0]          m_sync_q, s_sync_q;
   logic                m_lvl_q, s_lvl_q;
   logic [DEB_EXP-1:0]  m_cnt_q, s_cnt_q;
   logic [BASE_EXP-1:0] tick_q, tick_d, tick_max;
   logic [2:0]          pos_q, pos_d, pos_n;
   dir_t                dir_q, dir_d, dir_n;
   logic [1:0]          mode_q, mode_d, speed_q, speed_d;
   logic                m_diff, s_diff, m_done, s_done, m_press, s_press, step, at_end;
   logic [7:0]          win;
   assign m_diff   = m_sync_q[1] ^ m_lvl_q;
   assign s_diff   = s_sync_q[1] ^ s_lvl_q;
   assign m_done   = &m_cnt_q;
   assign s_done   = &s_cnt_q;
   // a press is the debounced level rising on this very edge
   assign m_press  = m_diff & m_done & m_sync_q[1];
   assign s_press  = s_diff & s_done & s_sync_q[1];
   assign tick_max = {BASE_EXP{1'b1}} >> speed_q;
   always_comb begin
      step    = (tick_q == tick_max) && !(m_press || s_press);
      tick_d  = (m_press || s_press || step) ? '0 : tick_q + BASE_EXP'(1);
      mode_d  = mode_q + {1'b0, m_press};
      speed_d = speed_q + {1'b0, s_press};
      // turning at an end flips dir first, then the move follows the new dir
      at_end  = (dir_q == RIGHT) ? (pos_q == 3'd5) : (pos_q == 3'd0);
      dir_n   = at_end ? ((dir_q == RIGHT) ? LEFT : RIGHT) : dir_q;
      pos_n   = (dir_n == RIGHT) ? pos_q + 3'd1 : pos_q - 3'd1;
      pos_d   = m_press ? 3'd0 : step ? pos_n : pos_q;
      dir_d   = m_press ? RIGHT : step ? dir_n : dir_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sync_q <= '0;
         s_sync_q <= '0;
         m_lvl_q  <= 1'b0;
         s_lvl_q  <= 1'b0;
         m_cnt_q  <= '0;
         s_cnt_q  <= '0;
         tick_q   <= '0;
         pos_q    <= 3'd0;
         dir_q    <= RIGHT;
         mode_q   <= 2'd0;
         speed_q  <= 2'd0;
      end else begin
         m_sync_q <= {m_sync_q[0], btn_mode};
         s_sync_q <= {s_sync_q[0], btn_speed};
         m_cnt_q  <= (m_diff && !m_done) ? m_cnt_q + DEB_EXP'(1) : '0;
         s_cnt_q  <= (s_diff && !s_done) ? s_cnt_q + DEB_EXP'(1) : '0;
         m_lvl_q  <= (m_diff && m_done) ? m_sync_q[1] : m_lvl_q;
         s_lvl_q  <= (s_diff && s_done) ? s_sync_q[1] : s_lvl_q;
         tick_q   <= tick_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         speed_q  <= speed_d;
      end
   end
   always_comb begin
      win        = 8'hE0 >> pos_q;
      shiftR_out = (mode_q == 2'd0 || mode_q == 2'd2 || (mode_q == 2'd3 && dir_q == RIGHT)) ? win : 8'h00;
      shiftG_out = (mode_q == 2'd1 || mode_q == 2'd2 || (mode_q == 2'd3 && dir_q == LEFT)) ? win : 8'h00;
   end
   assign ctl_bit = 1'b1;
   assign mode    = mode_q;
   assign speed   = speed_q;
endmodule

// File: tb/tb_chase_sched.sv
// tb_chase_sched: vector table + scoreboard bench for chase_sched at BASE_EXP=4, DEB_EXP=2
module tb_chase_sched;
   localparam int BE = 4;
   localparam int DE = 2;
   logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_speed = 1'b0;
   logic [7:0] r, g;
   logic       ctl;
   logic [1:0] mode, speed;
   chase_sched #(.BASE_EXP(BE), .DEB_EXP(DE)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_speed(btn_speed),
      .shiftR_out(r), .shiftG_out(g), .ctl_bit(ctl), .mode(mode), .speed(speed)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit rst; logic bm; logic bs; int n;
      logic [7:0] r; logic [7:0] g; logic [1:0] m; logic [1:0] s; string nm;
   } vec_t;
   typedef struct { int cyc; logic [20:0] exp; string nm; } sb_t;
   int   n_cmp = 0, n_bad = 0, cyc = 0;
   sb_t  sb[$];
   vec_t tbl[$];
   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got r=%h g=%h m=%0d s=%0d ctl=%b, want r=%h g=%h m=%0d s=%0d ctl=%b",
                  nm, cyc, act[20:13], act[12:5], act[4:3], act[2:1], act[0],
                  exp[20:13], exp[12:5], exp[4:3], exp[2:1], exp[0]);
      end
   endtask
   always @(negedge clk) begin
      sb_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expected at cyc %0d, now %0d", e.nm, e.cyc, cyc);
         end else chk(e.nm, {r, g, mode, speed, ctl}, e.exp);
      end
   end
   function automatic void add(input bit rst, input logic bm, input logic bs, input int n,
                               input logic [7:0] er, input logic [7:0] eg,
                               input logic [1:0] em, input logic [1:0] es, input string nm);
      vec_t v;
      v.rst = rst; v.bm = bm; v.bs = bs; v.n = n;
      v.r = er; v.g = eg; v.m = em; v.s = es; v.nm = nm;
      tbl.push_back(v);
   endfunction
   task automatic run_vec(input vec_t v);
      sb_t e;
      if (v.rst) begin
         @(negedge clk);
         #1 reset = 1'b1;
         btn_mode = 1'b0;
         btn_speed = 1'b0;
         @(posedge clk);
         @(posedge clk);
         #1 reset = 1'b0;
      end
      btn_mode = v.bm;
      btn_speed = v.bs;
      e.cyc = cyc + v.n;
      e.exp = {v.r, v.g, v.m, v.s, 1'b1};
      e.nm = v.nm;
      sb.push_back(e);
      repeat (v.n) @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] seq [12];
      vec_t v;
      seq = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};
      // free-running step sequence: value holds for 16 edges, changes on edge 16*i
      add(1, 0, 0, 0,  8'hE0, 8'h00, 0, 0, "reset_state");
      add(0, 0, 0, 15, 8'hE0, 8'h00, 0, 0, "step0_hold");
      for (int i = 1; i < 12; i++) begin
         add(0, 0, 0, 1,  seq[i], 8'h00, 0, 0, $sformatf("step%0d_edge", i));
         add(0, 0, 0, 15, seq[i], 8'h00, 0, 0, $sformatf("step%0d_hold", i));
      end
      // mode press latency (button rises before edge 1, action at edge 6) and restart
      add(1, 1, 0, 5,  8'hE0, 8'h00, 0, 0, "mode_pre");
      add(0, 1, 0, 1,  8'h00, 8'hE0, 1, 0, "mode_edge");
      add(0, 1, 0, 15, 8'h00, 8'hE0, 1, 0, "mode_hold");
      add(0, 1, 0, 1,  8'h00, 8'h70, 1, 0, "mode_step");
      // bounce rejection
      add(1, 1, 0, 3,  8'hE0, 8'h00, 0, 0, "bounce1");
      add(0, 0, 0, 3,  8'hE0, 8'h00, 0, 0, "bounce2");
      add(0, 1, 0, 3,  8'hE0, 8'h00, 0, 0, "bounce3");
      add(0, 0, 0, 20, 8'h70, 8'h00, 0, 0, "bounce_end");
      // speed wrap, pos preserved, press overriding a due step
      add(1, 0, 0, 40, 8'h38, 8'h00, 0, 0, "spd_idle");
      add(0, 0, 1, 5,  8'h38, 8'h00, 0, 0, "spd1_pre");
      add(0, 0, 1, 1,  8'h38, 8'h00, 0, 1, "spd1_edge");
      add(0, 0, 1, 7,  8'h38, 8'h00, 0, 1, "spd1_hold");
      add(0, 0, 1, 1,  8'h1C, 8'h00, 0, 1, "spd1_step");
      add(0, 0, 0, 6,  8'h1C, 8'h00, 0, 1, "spd1_rel");
      add(0, 0, 1, 6,  8'h0E, 8'h00, 0, 2, "spd2_edge");
      add(0, 0, 1, 3,  8'h0E, 8'h00, 0, 2, "spd2_hold");
      add(0, 0, 1, 1,  8'h07, 8'h00, 0, 2, "spd2_step");
      add(0, 0, 0, 6,  8'h0E, 8'h00, 0, 2, "spd2_rel");
      add(0, 0, 1, 6,  8'h1C, 8'h00, 0, 3, "spd3_edge_nostep");
      add(0, 0, 1, 1,  8'h1C, 8'h00, 0, 3, "spd3_hold");
      add(0, 0, 1, 1,  8'h38, 8'h00, 0, 3, "spd3_step1");
      add(0, 0, 1, 1,  8'h38, 8'h00, 0, 3, "spd3_hold2");
      add(0, 0, 1, 1,  8'h70, 8'h00, 0, 3, "spd3_step2");
      add(0, 0, 0, 6,  8'h38, 8'h00, 0, 3, "spd3_rel");
      add(0, 0, 1, 6,  8'h0E, 8'h00, 0, 0, "spd0_wrap_nostep");
      add(0, 0, 1, 15, 8'h0E, 8'h00, 0, 0, "spd0_hold");
      add(0, 0, 1, 1,  8'h07, 8'h00, 0, 0, "spd0_step");
      // walk mode to 3, then check direction-dependent routing
      add(1, 1, 0, 6,  8'h00, 8'hE0, 1, 0, "m1");
      add(0, 0, 0, 6,  8'h00, 8'hE0, 1, 0, "m1_rel");
      add(0, 1, 0, 6,  8'hE0, 8'hE0, 2, 0, "m2_yellow");
      add(0, 0, 0, 6,  8'hE0, 8'hE0, 2, 0, "m2_rel");
      add(0, 1, 0, 6,  8'hE0, 8'h00, 3, 0, "m3_start");
      add(0, 0, 0, 80, 8'h07, 8'h00, 3, 0, "m3_pos5_right");
      add(0, 0, 0, 16, 8'h00, 8'h0E, 3, 0, "m3_pos4_left");
      add(0, 0, 0, 64, 8'h00, 8'hE0, 3, 0, "m3_pos0_left");
      add(0, 0, 0, 16, 8'h70, 8'h00, 3, 0, "m3_pos1_right");
      // simultaneous presses landing on a due step edge
      add(1, 0, 0, 42, 8'h38, 8'h00, 0, 0, "sim_pre");
      add(0, 1, 1, 6,  8'h00, 8'hE0, 1, 1, "sim_edge");
      add(0, 1, 1, 7,  8'h00, 8'hE0, 1, 1, "sim_hold");
      add(0, 1, 1, 1,  8'h00, 8'h70, 1, 1, "sim_step");
      foreach (tbl[i]) run_vec(tbl[i]);
      // asynchronous reset mid-period, buttons still held
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async_reset", {r, g, mode, speed, ctl}, {8'hE0, 8'h00, 2'd0, 2'd0, 1'b1});
      @(posedge clk);
      #1 reset = 1'b0;
      v.rst = 0; v.bm = 1; v.bs = 1; v.n = 5;
      v.r = 8'hE0; v.g = 8'h00; v.m = 0; v.s = 0; v.nm = "held_pre";
      run_vec(v);
      v.n = 1; v.r = 8'h00; v.g = 8'hE0; v.m = 1; v.s = 1; v.nm = "held_press";
      run_vec(v);
      @(negedge clk);
      #1;
      while (sb.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never compared (expected at cyc %0d)", sb[0].nm, sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/chase_sched.md
# chase_sched

Mode and speed controller for the 8-LED meteor chaser on the dual-colour (red/green) LED bar. It generates its own step tick from the board clock and debounces two push-buttons: one selects the colour mode, the other selects the step speed. It sequences a 3-LED bouncing window and routes it to the red bank, the green bank, or both. It sits directly between the board pins and the LED drivers, and replaces the standalone divider-plus-shifter pair.

## Interface
- `BASE_EXP`, default 20: the slowest step period is 2^BASE_EXP clocks. Must be ≥ 4.
- `DEB_EXP`, default 16: a button must be stable for 2^DEB_EXP clocks to register. Must be ≥ 1.

Ports:
- `clk` in 1: board clock.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `btn_mode` in 1: raw mode button, active-high, asynchronous to `clk`.
- `btn_speed` in 1: raw speed button, active-high, asynchronous to `clk`.
- `shiftR_out` out 8: red LED bank, bit 7 = leftmost.
- `shiftG_out` out 8: green LED bank, bit 7 = leftmost.
- `ctl_bit` out 1: LED bank enable, constant 1.
- `mode` out 2: current colour mode.
- `speed` out 2: current speed level.

## Operation
- **Reset values:**
  - `pos` = 0, `dir` = RIGHT, `mode` = 0, `speed` = 0.
  - Tick counter = 0, synchronizers = 0, debounced levels = 0, debounce counters = 0.
  - Outputs: `shiftR_out` = 8'hE0, `shiftG_out` = 8'h00, `ctl_bit` = 1.
- **Synchronizer:** each button passes through a 2-flop synchronizer.
- **Debounce, per button:**
  - A counter of width DEB_EXP increments on every edge where the synced value differs from the debounced level.
  - On any agreeing edge the counter clears to 0.
  - On an edge where the counter equals 2^DEB_EXP−1 and the values still differ, the debounced level takes the synced value and the counter clears.
- **Press event:** a debounced 0→1 transition. The action takes effect on that same edge. Release (1→0) has no action.
- **Mode press:**
  - `mode` ← `mode`+1 mod 4.
  - `pos` ← 0, `dir` ← RIGHT, tick counter ← 0.
- **Speed press:**
  - `speed` ← `speed`+1 mod 4.
  - Tick counter ← 0; `pos` and `dir` are unchanged.
- **Simultaneous presses (same edge):** both actions apply.
- **Tick:**
  - Period P = 2^(BASE_EXP−`speed`).
  - The tick counter increments each edge. When it equals P−1, that edge is a step and the counter wraps to 0.
  - A button action on the same edge overrides: the counter clears and no step occurs.
- **Step:**
  - `pos` ranges 0..5. The lit window is bits [7−pos : 5−pos].
  - With `dir`=RIGHT: if `pos`<5 then `pos`+1; at `pos`=5, `pos`←4 and `dir`←LEFT.
  - With `dir`=LEFT: if `pos`>0 then `pos`−1; at `pos`=0, `pos`←1 and `dir`←RIGHT.
  - `dir` is the direction of the move that produced the current `pos`.
  - Resulting sequence: E0,70,38,1C,0E,07,0E,1C,38,70,E0,70,… with a period of 10 steps. Endpoints are shown once.
- **Colour routing** (`win` = window pattern):
  - Mode 0: R = `win`, G = 0.
  - Mode 1: R = 0, G = `win`.
  - Mode 2: R = G = `win` (yellow).
  - Mode 3: R = `win` when `dir`=RIGHT, otherwise G = `win`.
- **Output decode:** outputs are combinational from registered `pos`/`dir`/`mode`. `mode` and `speed` ports are the registers themselves.

## Timing
- **Debounce latency:** raw input rises before edge k and is held stable. The synced value is 1 after edge k+1. The debounced level rises and the action occurs at edge k+1+2^DEB_EXP.
- **Glitch rejection:** a bounce shorter than 2^DEB_EXP synced cycles produces no event.
- **Step latency after reset release:** the first step occurs on the 2^BASE_EXP-th edge. After a speed change the next step occurs P edges after the press edge.
- **Reset mid-count or mid-debounce:** everything returns to reset values immediately (asynchronous). A button held through reset is debounced afresh after release and generates a press.

## Test plan
- **Step sequence:** BASE_EXP=4, DEB_EXP=2, no buttons, run 200 clocks → `shiftR_out` steps every 16 clocks through E0,70,38,1C,0E,07,0E,1C,38,70,E0; `shiftG_out`=0 throughout.
- **Mode press latency and restart:** raise `btn_mode` before edge k and hold → `mode` goes 0→1 exactly at edge k+5; `shiftG_out`=E0 and `shiftR_out`=00 from that edge; the next step comes 16 edges later.
- **Bounce rejection:** toggle `btn_mode` 1,0,1,0 with 3-cycle pulses, then hold low → `mode` stays 0; the debounce counter never reaches 3 while values differ.
- **Speed wrap and step periods:** four `btn_speed` presses → `speed` goes 1,2,3,0; at speed 3 steps occur every 2 clocks; `pos` is preserved across each press.
- **Mode 3 routing:** at `pos`=5 (07), R=07 and G=00; next step gives G=0E and R=00; at the return to E0, G=E0; next step gives R=70.
- **Simultaneous press and asynchronous reset:** assert both buttons on the same edge → `mode`+1 and `speed`+1, `pos`=0, no step on that edge. Then assert `reset` mid-period → all outputs are at reset values before the next edge.
